rv_test_monitor: RTL
====================

Name: rv_test_monitor

Overview:
- Synthesizable end-of-test monitor that sits directly downstream of the RV64I core.
- Consumes the core's retire stream (committed PC) and register-file write port.
- Tracks a shadow copy of the result register (x3/gp), detects the end-of-test PC and produces a pass/fail/timeout verdict.
- Reports the captured result code, cycle count and retired-instruction count, so benches and FPGA builds check tests without hierarchical peeking.

Parameters:
- XLEN, 64, datapath/PC width
- END_PC, 64'h0000_001c, committed PC that marks end of test
- RESULT_REG, 3, architectural register holding the test result (0 = pass)
- MAX_CYCLES, 100000, watchdog limit in RUN cycles; must be < 2^CNT_W
- CNT_W, 32, width of cycle and instruction counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  arm pulse; starts a run
- retire_i  in  1  one instruction committed this cycle
- retire_pc_i  in  XLEN  PC of committed instruction (valid with retire_i)
- rf_we_i  in  1  register-file write enable
- rf_waddr_i  in  5  register-file write address
- rf_wdata_i  in  XLEN  register-file write data
- busy_o  out  1  high in RUN
- done_o  out  1  high in PASS, FAIL or TIMEOUT
- pass_o  out  1  high in PASS
- fail_o  out  1  high in FAIL
- timeout_o  out  1  high in TIMEOUT
- end_pulse_o  out  1  one-cycle pulse on the cycle after entering any terminal state
- result_o  out  XLEN  result value latched at end of test
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed
- instr_cnt_o  out  CNT_W  instructions retired in RUN

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; all outputs 0.
  - Shadow register and counters = 0.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT. All outputs are registered and decoded from the state and registers.
- Shadow register:
  - Updated in IDLE and RUN when rf_we_i=1 and rf_waddr_i==RESULT_REG.
  - Writes to other addresses are ignored. A write to address 0 never updates the shadow, even if RESULT_REG is misconfigured as 0.
  - Frozen in terminal states.
- IDLE -> RUN on start_i. On that transition, counters and shadow are cleared. start_i has priority over a same-cycle shadow write.
- PASS/FAIL/TIMEOUT -> RUN on start_i, with the same clears (re-arm for back-to-back tests). Terminal states are otherwise sticky.
- start_i in RUN is ignored.
- Every RUN cycle:
  - cycle_cnt increments by 1; this includes the terminating cycle.
  - instr_cnt increments when retire_i=1, saturating at all-ones.
- End detection in RUN: retire_i=1 and retire_pc_i==END_PC, compared on the full XLEN bits.
  - The effective result is rf_wdata_i if a RESULT_REG write occurs in the same cycle; otherwise it is the shadow value.
  - result_o latches the effective result.
  - Next state is PASS if the effective result == 0, else FAIL.
- Watchdog: in RUN with cycle_cnt == MAX_CYCLES-1 and no end detection, next state is TIMEOUT. cycle_cnt becomes MAX_CYCLES. result_o latches the shadow value.
- End detection and watchdog in the same cycle: end detection wins (PASS/FAIL).
- retire_pc_i is ignored when retire_i=0. Retires outside RUN are not counted.
- end_pulse_o: asserted exactly one cycle, on the first cycle in which done_o=1.
- Reset asserted mid-run: immediate return to IDLE with everything cleared; no end_pulse_o is generated.

Test Plan:
- Reset, start, write x3 := 5 then x3 := 0, retire PCs 0x0, 0x4, 0x1c -> PASS, result_o=0, instr_cnt_o=3, single end_pulse_o, done_o held.
- Start, write x3 := 0x2A, retire 0x1c -> FAIL, result_o=0x2A. Same cycle as the end retire, write x3 := 0 -> PASS (same-cycle write used).
- Start, retire_pc_i=0x1c with retire_i=0, plus writes to x4/x0 with data 7 -> stays RUN, shadow still 0, instr_cnt_o=0.
- MAX_CYCLES=20, start, no end PC -> TIMEOUT, cycle_cnt_o=20. Repeat with END_PC retired on cycle 20 -> PASS, not TIMEOUT.
- After FAIL, pulse start_i, run a passing sequence -> counters restart from 0, PASS. Pulse start_i during RUN -> no effect.
- Assert rst for 3 ns mid-run (not clock-aligned) -> all outputs 0 immediately, state IDLE, no end_pulse_o.

Source files
------------

// File: rtl/rv_test_monitor.sv
// End-of-test monitor for the RV64I core: shadows the result register, watches
// the retire stream for the end PC and reports pass/fail/timeout plus counters.
module rv_test_monitor #(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] END_PC     = 'h0000_001c,
    parameter int              RESULT_REG = 3,
    parameter int              MAX_CYCLES = 100000,
    parameter int              CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             retire_i,
    input  logic [XLEN-1:0]  retire_pc_i,
    input  logic             rf_we_i,
    input  logic [4:0]       rf_waddr_i,
    input  logic [XLEN-1:0]  rf_wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic             end_pulse_o,
    output logic [XLEN-1:0]  result_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TIMEOUT
    } state_t;

    localparam logic [4:0]       RES_ADDR = 5'(RESULT_REG);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);

    state_t            state, state_nxt;
    logic [XLEN-1:0]   shadow;
    logic [XLEN-1:0]   result_r;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;
    logic              end_pulse_r;

    logic              res_wr;
    logic              end_hit;
    logic              wd_hit;
    logic              arm;
    logic [XLEN-1:0]   eff_result;

    // x0 is hard-wired zero, so it can never feed the shadow even if misconfigured
    assign res_wr     = rf_we_i && (rf_waddr_i == RES_ADDR) && (rf_waddr_i != 5'd0);
    assign end_hit    = (state == S_RUN) && retire_i && (retire_pc_i == END_PC);
    assign wd_hit     = (state == S_RUN) && (cycle_cnt == WD_LAST);
    assign arm        = start_i && (state != S_RUN);
    assign eff_result = res_wr ? rf_wdata_i : shadow;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
                if (start_i) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (end_hit)     state_nxt = (eff_result == '0) ? S_PASS : S_FAIL;
                else if (wd_hit) state_nxt = S_TIMEOUT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shadow      <= '0;
            result_r    <= '0;
            cycle_cnt   <= '0;
            instr_cnt   <= '0;
            end_pulse_r <= 1'b0;
        end else begin
            state       <= state_nxt;
            end_pulse_r <= (state == S_RUN) && (state_nxt != S_RUN);
            if (arm) begin
                shadow    <= '0;
                cycle_cnt <= '0;
                instr_cnt <= '0;
            end else if (state == S_RUN) begin
                cycle_cnt <= cycle_cnt + 1'b1;
                if (retire_i && (instr_cnt != '1)) instr_cnt <= instr_cnt + 1'b1;
                if (res_wr) shadow <= rf_wdata_i;
                // end detection outranks the watchdog on a coincident cycle
                if (end_hit)     result_r <= eff_result;
                else if (wd_hit) result_r <= shadow;
            end else if ((state == S_IDLE) && res_wr) begin
                shadow <= rf_wdata_i;
            end
        end
    end

    assign busy_o      = (state == S_RUN);
    assign pass_o      = (state == S_PASS);
    assign fail_o      = (state == S_FAIL);
    assign timeout_o   = (state == S_TIMEOUT);
    assign done_o      = pass_o || fail_o || timeout_o;
    assign end_pulse_o = end_pulse_r;
    assign result_o    = result_r;
    assign cycle_cnt_o = cycle_cnt;
    assign instr_cnt_o = instr_cnt;

endmodule
